// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the single-precision multiplier:
//   - fpState  : sequencer states IDLE -> MULT -> NORM -> ROUND
//   - EXP_BIAS : IEEE-754 single-precision exponent bias
//   - QNAN     : canonical quiet NaN returned for every invalid operation
//   - POS_INF  : positive infinity encoding
//   - signedInf / signedZero : helpers that pack a signed special value
// ---------------------------------------------------------------------------
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    NORM  = 2'd2,
    ROUND = 2'd3
  } fpState;

  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;

  // Infinity with the requested sign; the magnitude bits come from POS_INF.
  function automatic logic [31:0] signedInf(input logic sign);
    return {sign, POS_INF[30:0]};
  endfunction

  function automatic logic [31:0] signedZero(input logic sign);
    return {sign, 31'b0};
  endfunction

endpackage

// File: rtl/fp_classify.sv
// ---------------------------------------------------------------------------
// fp_classify
// Splits one single-precision operand into its fields and flags the special
// encodings the multiplier must handle separately.
// Ports:
//   op     in  [31:0]  IEEE-754 single-precision value
//   sign   out         sign bit
//   expo   out [7:0]   biased exponent field
//   mant   out [23:0]  fraction with the hidden leading one restored
//   isZero out         exponent field is zero (denormals count as zero)
//   isInf  out         exponent all ones, fraction zero
//   isNan  out         exponent all ones, fraction non-zero
// ---------------------------------------------------------------------------
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] op,
  output logic        sign,
  output logic [7:0]  expo,
  output logic [23:0] mant,
  output logic        isZero,
  output logic        isInf,
  output logic        isNan
);

  logic expAllOnes;
  logic fracZero;

  // Pure field decode. Denormals are deliberately folded into zero, so the
  // hidden bit can always be forced to one for anything that reaches the
  // mantissa multiplier; zero/Inf/NaN never use the mantissa.
  always_comb begin
    sign       = op[31];
    expo       = op[30:23];
    mant       = {1'b1, op[22:0]};
    expAllOnes = (op[30:23] == 8'hFF);
    fracZero   = (op[22:0] == 23'b0);
    isZero     = (op[30:23] == 8'h00);
    isInf      = expAllOnes & fracZero;
    isNan      = expAllOnes & ~fracZero;
  end

endmodule

// File: rtl/multiplier_fp.sv
// ---------------------------------------------------------------------------
// multiplier_fp
// Four-state sequential IEEE-754 single-precision multiplier with round to
// nearest, ties to even. Denormal inputs are treated as zero and underflowing
// results flush to signed zero.
// Ports:
//   clk    in          rising-edge clock
//   rst    in          synchronous active-high reset
//   start  in          request, only looked at while idle
//   A, B   in  [31:0]  operands
//   busy   out         high while MULT, NORM or ROUND is in progress
//   ready  out         one-cycle pulse when Y carries a new result
//   Y      out [31:0]  product, held until the next result is written
// Timing: start captured on edge 0, MULT on edge 1, NORM on edge 2, ROUND
// writes Y on edge 3, so ready is high in the 4th cycle after capture.
// ---------------------------------------------------------------------------
module multiplier_fp
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        ready,
  output logic [31:0] Y
);

  fpState state;
  fpState nextState;

  // Registered operands; special cases are decoded from these, never from
  // the live inputs, so they follow the same latency as normal operands.
  logic [31:0] opA;
  logic [31:0] opB;

  logic        signA, signB;
  logic [7:0]  expoA, expoB;
  logic [23:0] mantA, mantB;
  logic        zeroA, zeroB, infA, infB, nanA, nanB;

  // MULT stage results
  logic               prodSign;
  logic signed [9:0]  expSum;
  logic [47:0]        prod;
  logic               isSpecial;
  logic [31:0]        specialVal;

  // NORM stage results
  logic signed [9:0]  normExp;
  logic [23:0]        normMant;
  logic               guardBit;
  logic               stickyBit;

  // ROUND stage combinational values
  logic               roundUp;
  logic [24:0]        roundSum;
  logic signed [9:0]  finalExp;
  logic [22:0]        finalFrac;
  logic [31:0]        roundResult;

  fp_classify classifyA (
    .op     (opA),
    .sign   (signA),
    .expo   (expoA),
    .mant   (mantA),
    .isZero (zeroA),
    .isInf  (infA),
    .isNan  (nanA)
  );

  fp_classify classifyB (
    .op     (opB),
    .sign   (signB),
    .expo   (expoB),
    .mant   (mantB),
    .isZero (zeroB),
    .isInf  (infB),
    .isNan  (nanB)
  );

  // State register. Reset wins over everything, which also aborts an
  // operation in flight before its ready pulse can be produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: a fixed walk through the pipeline once started.
  // start is only consulted in IDLE, so requests during an operation are
  // dropped. busy is simply "not idle".
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = MULT;
        end
      end
      MULT: begin
        busy      = 1'b1;
        nextState = NORM;
      end
      NORM: begin
        busy      = 1'b1;
        nextState = ROUND;
      end
      ROUND: begin
        busy      = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Round to nearest, ties to even. A carry out of the 24-bit mantissa means
  // it rolled over to exactly 2.0, so the fraction becomes zero and the
  // exponent grows by one. Overflow and underflow are judged on the final
  // exponent, after that possible increment.
  always_comb begin
    roundUp  = guardBit & (stickyBit | normMant[0]);
    roundSum = {1'b0, normMant} + {24'b0, roundUp};
    if (roundSum[24]) begin
      finalFrac = roundSum[23:1];
      finalExp  = normExp + 10'sd1;
    end else begin
      finalFrac = roundSum[22:0];
      finalExp  = normExp;
    end

    if (isSpecial) begin
      roundResult = specialVal;
    end else if (finalExp >= 10'sd255) begin
      roundResult = signedInf(prodSign);
    end else if (finalExp <= 10'sd0) begin
      roundResult = signedZero(prodSign);
    end else begin
      roundResult = {prodSign, finalExp[7:0], finalFrac};
    end
  end

  // Datapath registers, one group updated per state. ready defaults low
  // every cycle so it can only ever be a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      opA        <= 32'b0;
      opB        <= 32'b0;
      Y          <= 32'b0;
      ready      <= 1'b0;
      prodSign   <= 1'b0;
      expSum     <= 10'sd0;
      prod       <= 48'b0;
      isSpecial  <= 1'b0;
      specialVal <= 32'b0;
      normExp    <= 10'sd0;
      normMant   <= 24'b0;
      guardBit   <= 1'b0;
      stickyBit  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opA <= A;
            opB <= B;
          end
        end
        MULT: begin
          prodSign <= signA ^ signB;
          expSum   <= signed'({2'b00, expoA} + {2'b00, expoB} - 10'(EXP_BIAS));
          prod     <= {24'b0, mantA} * {24'b0, mantB};
          // NaN and Inf*0 are invalid; Inf beats any finite; zero beats
          // any remaining finite value.
          if (nanA | nanB | (infA & zeroB) | (zeroA & infB)) begin
            isSpecial  <= 1'b1;
            specialVal <= QNAN;
          end else if (infA | infB) begin
            isSpecial  <= 1'b1;
            specialVal <= signedInf(signA ^ signB);
          end else if (zeroA | zeroB) begin
            isSpecial  <= 1'b1;
            specialVal <= signedZero(signA ^ signB);
          end else begin
            isSpecial  <= 1'b0;
            specialVal <= 32'b0;
          end
        end
        NORM: begin
          // Two normal mantissas give a product in [1,4); bit 47 set means
          // it is in [2,4) and needs a one-place right shift.
          if (prod[47]) begin
            normMant  <= prod[47:24];
            guardBit  <= prod[23];
            stickyBit <= |prod[22:0];
            normExp   <= expSum + 10'sd1;
          end else begin
            normMant  <= prod[46:23];
            guardBit  <= prod[22];
            stickyBit <= |prod[21:0];
            normExp   <= expSum;
          end
        end
        ROUND: begin
          Y     <= roundResult;
          ready <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_fp.sv
// ---------------------------------------------------------------------------
// tb_multiplier_fp
// Directed self-checking bench for multiplier_fp. Each operation is checked
// cycle by cycle: busy for three cycles, then a single ready pulse carrying
// the hand-computed product.
// ---------------------------------------------------------------------------
module tb_multiplier_fp;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        ready;
  logic [31:0] Y;

  int assertCount;
  int failCount;

  multiplier_fp dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .ready (ready),
    .Y     (Y)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents operands with start for exactly one rising edge and returns
  // 1 ns after that capture edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Full operation: capture, three busy cycles, then the ready cycle.
  // Returns 1 ns into the ready cycle so a following op can start there.
  task automatic runOp(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected);
    applyStimulus(a, b);
    checkOutput({tag, " busy c1"}, 32'(busy), 32'd1);
    checkOutput({tag, " ready c1"}, 32'(ready), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput({tag, " busy mid"}, 32'(busy), 32'd1);
      checkOutput({tag, " ready mid"}, 32'(ready), 32'd0);
    end
    @(posedge clk);
    #1;
    checkOutput({tag, " ready"}, 32'(ready), 32'd1);
    checkOutput({tag, " busy done"}, 32'(busy), 32'd0);
    checkOutput({tag, " Y"}, Y, expected);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst   = 1'b1;
    start = 1'b1;
    A     = 32'h40C00000;
    B     = 32'h40200000;

    // Reset with start held high: reset must win
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ready", 32'(ready), 32'd0);
    checkOutput("reset Y", Y, 32'h00000000);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle busy", 32'(busy), 32'd0);

    // Basic products
    runOp("6.0*2.5", 32'h40C00000, 32'h40200000, 32'h41700000);
    @(posedge clk);
    #1;
    checkOutput("hold ready", 32'(ready), 32'd0);
    checkOutput("hold Y", Y, 32'h41700000);

    runOp("-2*3", 32'hC0000000, 32'h40400000, 32'hC0C00000);
    runOp("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000);

    // Special operands
    runOp("inf*fin", 32'h7F800000, 32'h1EC22880, 32'h7F800000);
    runOp("inf*0", 32'h7F800000, 32'h00000000, 32'h7FC00000);
    runOp("nan*1", 32'h7F800001, 32'h3F800000, 32'h7FC00000);
    runOp("-inf*-2", 32'hFF800000, 32'hC0000000, 32'h7F800000);
    runOp("inf*-inf", 32'h7F800000, 32'hFF800000, 32'hFF800000);
    runOp("-0*2", 32'h80000000, 32'h40000000, 32'h80000000);
    runOp("denorm*-1", 32'h00000001, 32'hBF800000, 32'h80000000);
    runOp("underflow", 32'h80800000, 32'h3F000000, 32'h80000000);

    // Rounding: tie with odd lsb rounds up, tie with even lsb stays,
    // and an all-ones mantissa rounding up carries into the exponent
    runOp("tie odd", 32'h3F800001, 32'h40400000, 32'h40400002);
    runOp("tie even", 32'h3F800003, 32'h3FC00000, 32'h3FC00004);
    runOp("carry", 32'h3FF80000, 32'h3F842108, 32'h40000000);

    // Back-to-back: each new start is issued in the previous ready cycle
    runOp("b2b 1", 32'h40C00000, 32'h40200000, 32'h41700000);
    runOp("b2b 2", 32'hC0000000, 32'h40400000, 32'hC0C00000);
    runOp("b2b 3", 32'h3F800001, 32'h40400000, 32'h40400002);
    @(posedge clk);
    #1;
    checkOutput("b2b tail ready", 32'(ready), 32'd0);
    checkOutput("b2b tail busy", 32'(busy), 32'd0);

    // start pulsed while busy must not disturb the running operation
    applyStimulus(32'h40C00000, 32'h40200000);
    A     = 32'h7F800001;
    B     = 32'h3F800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy-start busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("busy-start ready", 32'(ready), 32'd1);
    checkOutput("busy-start Y", Y, 32'h41700000);
    @(posedge clk);
    #1;
    checkOutput("busy-start no rerun ready", 32'(ready), 32'd0);
    checkOutput("busy-start no rerun busy", 32'(busy), 32'd0);

    // Reset in the middle of an operation aborts it without a ready pulse
    applyStimulus(32'hC0000000, 32'h40400000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort ready", 32'(ready), 32'd0);
    checkOutput("abort Y", Y, 32'h00000000);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("abort no ready", 32'(ready), 32'd0);
    end

    // Normal operation resumes after the abort
    runOp("after abort", 32'h40C00000, 32'h40200000, 32'h41700000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/multiplier_fp.md
MULTIPLIER_FP -- requirements
Module: multiplier_fp

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; the port order SHALL be clock, reset, then the remaining ports.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  32  IEEE-754 single-precision operand.
REQ-006 B  input  32  IEEE-754 single-precision operand.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 ready  output  1  one-cycle pulse marking Y valid.
REQ-009 Y  output  32  IEEE-754 single-precision product A*B.

Function
REQ-010 The FSM SHALL have the states IDLE -> MULT -> NORM -> ROUND -> IDLE, with one clock per state.
REQ-011 In IDLE with start=1, the FSM SHALL register A and B, set busy=1, and enter MULT.
REQ-012 start SHALL be ignored in every state except IDLE.
REQ-013 MULT: sign = A[31]^B[31]; exponent sum = eA+eB-127, 10-bit signed; full 24x24 -> 48-bit mantissa product with hidden bits.
REQ-014 NORM: if product bit 47 = 1, shift right by 1 and add 1 to the exponent; keep 24 mantissa bits plus guard bit and sticky bit (OR of the remaining bits).
REQ-015 ROUND: round to nearest, ties to even; a mantissa carry-out SHALL renormalise and increment the exponent.
REQ-016 On the ROUND edge: write Y, set ready=1 for exactly one cycle, clear busy, return to IDLE.
REQ-017 Latency: ready SHALL be high in the 4th cycle after the start-capture edge.
REQ-018 Y SHALL hold its value until the next result is written.
REQ-019 start=1 in the same cycle as ready SHALL begin a new operation; ready drops on the next cycle.
REQ-020 Denormal inputs (exp=0) SHALL be treated as signed zero.
REQ-021 Result exponent >= 255 after rounding SHALL give signed infinity (exp=FF, frac=0).
REQ-022 Result exponent <= 0 SHALL flush to signed zero.
REQ-023 Either operand NaN SHALL give canonical quiet NaN 32'h7FC00000.
REQ-024 Inf*0 SHALL give 32'h7FC00000.
REQ-025 Inf*nonzero finite or Inf*Inf SHALL give signed infinity.
REQ-026 Zero*finite SHALL give signed zero (sign = XOR of operand signs).
REQ-027 Special cases SHALL be resolved from the registered operands and SHALL take the same 4-cycle latency as normal operands.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, busy=0, ready=0, Y=32'h00000000, operand registers=0.
REQ-029 rst SHALL override start.
REQ-030 Reset during MULT, NORM or ROUND SHALL abort the operation with no ready pulse.

Structure
REQ-031 Package fp_pkg SHALL hold: the state enum; EXP_BIAS=127; QNAN=32'h7FC00000; POS_INF=32'h7F800000.
REQ-032 Sub-module fp_classify SHALL decode one operand into sign/exp/mantissa-with-hidden-bit and is_zero/is_inf/is_nan flags; it SHALL be instantiated twice.

Verification
REQ-033 A=40C00000 (6.0), B=40200000 (2.5), start one cycle -> busy high for 3 cycles, then ready one cycle with Y=41700000 (15.0).
REQ-034 A=7F800000 (+Inf), B=1EC22880 -> Y=7F800000; A=7F800000, B=00000000 -> Y=7FC00000.
REQ-035 A=7F800001 (NaN), B=3F800000 -> Y=7FC00000.
REQ-036 A=C0000000 (-2.0), B=40400000 (3.0) -> Y=C0C00000; A=7F000000, B=40000000 -> Y=7F800000 (overflow).
REQ-037 Pulse start while busy=1 -> no effect on the running operation.
REQ-038 Assert rst mid-operation -> ready stays 0; busy=0 and Y=0 on the next cycle.
REQ-039 Back-to-back operations, with start asserted during the ready cycle -> each result is correct and exactly one ready pulse occurs per operation.
